vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_timing_gen_if.sv | 39 +++
 rtl/vga_delay_line.sv | 30 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, per-axis timing struct and width helpers.
// No logic of its own; latency not applicable.
// No flow control; constants and pure functions only.
package vga_pkg;

  // 640x480@60 with a 25 MHz pixel clock (800 x 525 totals)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // One axis of a video timing: region lengths in the order they occur
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;

  localparam vga_axis_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
  localparam vga_axis_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

  // Total clocks (or lines) of one axis period
  function automatic int axis_total(input vga_axis_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  // Bits needed to hold 0..n-1, never less than one
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the timing generator: colour in, coordinates, syncs and blanked colour out.
// Pure wiring, zero latency.
// No backpressure; the display side consumes every enabled pixel.
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int COLOR_W = 8,
  parameter int XW      = cnt_w(VGA_H_ACTIVE),
  parameter int YW      = cnt_w(VGA_V_ACTIVE)
);

  logic [COLOR_W-1:0] red_in;
  logic [COLOR_W-1:0] green_in;
  logic [COLOR_W-1:0] blue_in;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic               de_early;
  logic               h_sync;
  logic               v_sync;
  logic               de;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               frame_start;
  logic               line_start;

  // Timing generator side
  modport master (
    input  red_in, green_in, blue_in,
    output x, y, de_early, h_sync, v_sync, de, red, green, blue, frame_start, line_start
  );

  // Pixel source / display side
  modport slave (
    output red_in, green_in, blue_in,
    input  x, y, de_early, h_sync, v_sync, de, red, green, blue, frame_start, line_start
  );

endinterface

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register that aligns control bits with a delayed data path.
// Latency: DEPTH enabled cycles from din to dout.
// No backpressure; contents freeze while ce is low.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  // Shift one stage per enabled cycle; reset loads the inactive value everywhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (ce) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, coordinates, line/frame pulses, aligned syncs and blanked colour.
// Latency: x/y/de_early/pulses undelayed; syncs, de and colour PIPE_LAT+1 enabled cycles later.
// No backpressure; pix_ce low freezes all state and outputs and drops the pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int COLOR_W  = 8
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             pix_ce,
  vga_timing_gen_if.master vif
);

  localparam vga_axis_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam vga_axis_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int H_TOTAL = axis_total(H_TIM);
  localparam int V_TOTAL = axis_total(V_TIM);
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);
  localparam int XW      = cnt_w(H_ACTIVE);
  localparam int YW      = cnt_w(V_ACTIVE);

  // Compare points sized to the counters; sync end is inclusive so it never reaches TOTAL
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_L = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_L = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               act_raw;
  logic               hs_raw;
  logic               vs_raw;
  logic               de_int;
  logic [2:0]         dl_out;
  logic               hs_d;
  logic               vs_d;
  logic               de_d;
  logic [COLOR_W-1:0] red_q;
  logic [COLOR_W-1:0] green_q;
  logic [COLOR_W-1:0] blue_q;

  // Raster counters: h every enabled cycle, v on each h wrap, both wrap at frame end
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  assign act_raw = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_raw  = (h_cnt >= H_SYNC_S) && (h_cnt <= H_SYNC_L);
  assign vs_raw  = (v_cnt >= V_SYNC_S) && (v_cnt <= V_SYNC_L);

  // Counters sit at the frame origin during reset, so the undelayed outputs are
  // gated by reset to read inactive immediately rather than at the next edge.
  assign de_int           = reset & act_raw;
  assign vif.de_early     = de_int;
  assign vif.x            = de_int ? h_cnt[XW-1:0] : '0;
  assign vif.y            = de_int ? v_cnt[YW-1:0] : '0;
  assign vif.line_start   = reset & pix_ce & (h_cnt == '0);
  assign vif.frame_start  = reset & pix_ce & (h_cnt == '0) & (v_cnt == '0);

  // Syncs and de travel one stage longer than the source latency to meet the colour register
  vga_delay_line #(
    .W       (3),
    .DEPTH   (PIPE_LAT + 1),
    .RST_VAL (3'b000)
  ) u_delay (
    .clk   (clk_25mhz),
    .rst_n (reset),
    .ce    (pix_ce),
    .din   ({hs_raw, vs_raw, act_raw}),
    .dout  (dl_out)
  );

  assign {hs_d, vs_d, de_d} = dl_out;

  // Colour output register, one enabled cycle behind the source
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pix_ce) begin
      red_q   <= vif.red_in;
      green_q <= vif.green_in;
      blue_q  <= vif.blue_in;
    end
  end

  // Blank colour outside active video; polarity is applied after alignment
  assign vif.red   = de_d ? red_q   : '0;
  assign vif.green = de_d ? green_q : '0;
  assign vif.blue  = de_d ? blue_q  : '0;
  assign vif.de     = de_d;
  assign vif.h_sync = hs_d ? HS_POL : ~HS_POL;
  assign vif.v_sync = vs_d ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for two small-raster timing generators (different latency/polarity).
// Expected outputs come from an arithmetic raster model indexed by enabled-cycle count.
// Stimulus pushes one expectation per cycle; a negedge monitor pops and compares.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [2:0] x;
    logic [1:0] y;
    logic       de_early;
    logic       h_sync;
    logic       v_sync;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       frame_start;
    logic       line_start;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] r_in = '0;
  logic [7:0] g_in = '0;
  logic [7:0] b_in = '0;

  obs_t q_a[$];
  obs_t q_b[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_en = 0;
  int   cyc = 0;
  logic [23:0] col_hist [0:8191];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_W(8), .XW(3), .YW(2)) vif_a ();
  vga_timing_gen_if #(.COLOR_W(8), .XW(3), .YW(2)) vif_b ();

  assign vif_a.red_in = r_in;
  assign vif_a.green_in = g_in;
  assign vif_a.blue_in = b_in;
  assign vif_b.red_in = r_in;
  assign vif_b.green_in = g_in;
  assign vif_b.blue_in = b_in;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(2), .COLOR_W(8)
  ) dut_a (
    .clk_25mhz (clk),
    .reset     (rst_n),
    .pix_ce    (ce),
    .vif       (vif_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(3), .V_FP(2), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(0), .COLOR_W(8)
  ) dut_b (
    .clk_25mhz (clk),
    .reset     (rst_n),
    .pix_ce    (ce),
    .vif       (vif_b)
  );

  // Raster position is n mod line / frame length; delayed outputs are the
  // undelayed rules evaluated lat+1 enabled cycles in the past.
  function automatic obs_t model(input int n, input bit en, input bit rst,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input int lat, input bit hp, input bit vp);
    obs_t o;
    int ht, vt, h, v, m, hm, vm;
    bit sh, sv, dd;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    o = '0;
    o.h_sync = ~hp;
    o.v_sync = ~vp;
    if (!rst) return o;
    h = n % ht;
    v = (n / ht) % vt;
    if (h < ha && v < va) begin
      o.de_early = 1'b1;
      o.x = 3'(h);
      o.y = 2'(v);
    end
    o.line_start  = en && (h == 0);
    o.frame_start = en && (h == 0) && (v == 0);
    if (n >= lat + 1) begin
      m  = n - lat - 1;
      hm = m % ht;
      vm = (m / ht) % vt;
      sh = (hm >= ha + hf) && (hm < ha + hf + hs);
      sv = (vm >= va + vf) && (vm < va + vf + vs);
      dd = (hm < ha) && (vm < va);
      o.h_sync = sh ? hp : ~hp;
      o.v_sync = sv ? vp : ~vp;
      o.de = dd;
      if (dd) {o.r, o.g, o.b} = col_hist[n - 1];
    end
    return o;
  endfunction

  task automatic drive_cycle(input bit new_rst, input bit new_ce, input logic [23:0] col);
    @(posedge clk);
    if (!rst_n) n_en = 0;
    else if (ce) n_en++;
    #1;
    rst_n = new_rst;
    ce = new_ce;
    {r_in, g_in, b_in} = col;
    if (new_rst && new_ce) col_hist[n_en] = col;
    q_a.push_back(model(n_en, new_ce, new_rst, 8, 2, 3, 2, 4, 1, 2, 1, 2, 1'b0, 1'b0));
    q_b.push_back(model(n_en, new_ce, new_rst, 6, 1, 2, 3, 3, 2, 1, 1, 0, 1'b1, 1'b1));
    cyc++;
  endtask

  // Monitor: compare every presented cycle of both DUTs against the queued expectation
  always @(negedge clk) begin
    obs_t got, exp_v;
    if (cyc > 0) begin
      got = '{x: vif_a.x, y: vif_a.y, de_early: vif_a.de_early, h_sync: vif_a.h_sync,
              v_sync: vif_a.v_sync, de: vif_a.de, r: vif_a.red, g: vif_a.green, b: vif_a.blue,
              frame_start: vif_a.frame_start, line_start: vif_a.line_start};
      n_vec++;
      if (q_a.size() == 0) begin
        n_bad++;
        $display("FAIL dut_a_queue cyc=%0d: no expectation queued, got=%h", cyc, got);
      end else begin
        exp_v = q_a.pop_front();
        if (got !== exp_v) begin
          n_bad++;
          $display("FAIL dut_a cyc=%0d n=%0d got=%h exp=%h", cyc, n_en, got, exp_v);
        end
      end
      got = '{x: vif_b.x, y: vif_b.y, de_early: vif_b.de_early, h_sync: vif_b.h_sync,
              v_sync: vif_b.v_sync, de: vif_b.de, r: vif_b.red, g: vif_b.green, b: vif_b.blue,
              frame_start: vif_b.frame_start, line_start: vif_b.line_start};
      n_vec++;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL dut_b_queue cyc=%0d: no expectation queued, got=%h", cyc, got);
      end else begin
        exp_v = q_b.pop_front();
        if (got !== exp_v) begin
          n_bad++;
          $display("FAIL dut_b cyc=%0d n=%0d got=%h exp=%h", cyc, n_en, got, exp_v);
        end
      end
    end
  end

  initial begin
    // Held in reset with pix_ce high: pulses and de_early must stay low
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 24'($urandom));
    // Free-running with full-scale red
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 1'b1, {8'hFF, 16'($urandom)});
    // pix_ce alternating: periods double, outputs hold on idle cycles
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, (i % 2) == 0, 24'($urandom));
    // Random enables with resets dropped in mid-frame
    for (int i = 0; i < 1500; i++) begin
      bit in_rst;
      in_rst = (i >= 400 && i <= 402) || (i == 900) || (i >= 1200 && i <= 1204);
      drive_cycle(!in_rst, $urandom_range(0, 3) != 0, 24'($urandom));
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: a=%0d b=%0d left, required 0", q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
